alu_ctrl_exec: RTL and testbench
================================

Name: alu_ctrl_exec

Overview:
Parametrised EX-stage successor to the combinational ALU control decoder. It merges ALUOp/funct decode, a registered ALU datapath and an iterative shift-add multiplier into one unit with a valid/ready handshake. It sits between the ID/EX pipeline register and EX/MEM, and drives the pipeline stall while a multiply is in flight. It adds xor, nor and slt, flags illegal funct codes, and makes the output fully defined for every input.

Parameters:
WIDTH, 32, operand and result width in bits (≥8, even).
MUL_STEP, 1, multiplier bits retired per cycle; must divide WIDTH; N = WIDTH/MUL_STEP.
CTRL_W, 4, width of the ALU control code.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous, active-high reset.
valid_i  in  1  operation presented.
ready_o  out  1  unit can accept; transfer occurs when valid_i && ready_o at a rising edge.
ALUOp_i  in  2  0 = nop/J (AND), 1 = R-type, 2 = addi, 3 = lw/sw.
funct_i  in  6  R-type function field.
src1_i  in  WIDTH  operand A.
src2_i  in  WIDTH  operand B.
result_o  out  WIDTH  registered result.
aluctrl_o  out  CTRL_W  decoded control code of the completed operation.
valid_o  out  1  one-cycle pulse: result_o, aluctrl_o and illegal_o are valid.
illegal_o  out  1  completed R-type op had an unsupported funct.
stall_o  out  1  equals !ready_o; drives the hazard unit.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; result_o=0; aluctrl_o=0; valid_o=0; illegal_o=0; ready_o=1; stall_o=0; multiplier registers cleared. Reset aborts any multiply with no valid_o pulse, and it overrides a simultaneous valid_i.
- Decode (combinational, package constants):
  - ALUOp 0 → AND(0000); ALUOp 2 or 3 → ADD(0010).
  - ALUOp 1, by funct: 100000 ADD(0010), 100010 SUB(0110), 100100 AND(0000), 100101 OR(0001), 100110 XOR(0100), 100111 NOR(0101), 101010 SLT(0111), 011000 MUL(0011).
  - Any other funct → ILL(1111).
- Single-cycle ops (not MUL), accepted at edge E:
  - result_o and aluctrl_o register at E, and valid_o=1 for exactly the cycle following E.
  - ready_o stays 1, so back-to-back accepts give one result per cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare; result is 1 or 0, zero-extended.
- ILL: result_o=0, illegal_o=1 with the valid_o pulse. illegal_o=0 for every other op.
- MUL FSM:
  - IDLE --accept MUL--> BUSY: latch both operands, clear the accumulator, load count=N. ready_o=0 from the cycle after E.
  - BUSY: each cycle, add the low MUL_STEP bits of the multiplier times the shifted multiplicand into the accumulator, shift, and decrement count.
  - BUSY --count reaches 0--> IDLE: result_o = low WIDTH bits of the product (identical for signed and unsigned). valid_o pulses and ready_o returns to 1 in that same cycle.
  - Result appears N cycles after E (32 for the defaults). ready_o is low for exactly N−1 cycles.
- valid_i while ready_o=0 is ignored, and the inputs are not sampled.
- valid_o is a pulse with no backpressure; downstream must accept it.
- With no accept, valid_o=0 and result_o/aluctrl_o/illegal_o hold their last values.

Decomposition:
- Package alu_ctrl_pkg: ALUOp encodings (INST_REST/RTYPE/ADDI/MEM), funct constants, CTRL_W control-code constants (AND, OR, ADD, MUL, XOR, NOR, SUB, SLT, ILL), and the FSM state enum (IDLE, BUSY).
- One sub-module, iter_mul (WIDTH, MUL_STEP), with ports: start, a, b, busy, done, product.
- The top module holds decode, the single-cycle ALU, the output registers and the handshake.

Test Plan:
- ALUOp=1, funct=100000, src 5 and 7, valid_i one cycle → next cycle valid_o=1, result_o=12, aluctrl_o=0010, ready_o stays 1. Repeat with funct=100010, src 3 and 5 → 0xFFFFFFFE.
- Back-to-back: SLT (0xFFFFFFFF, 1), then XOR (0xF0F0F0F0, 0xFFFF0000), then NOR (0, 0) on consecutive cycles → results 1, 0x0F0FF0F0, 0xFFFFFFFF on three consecutive valid_o cycles.
- MUL 7 × 0xFFFFFFFD (−3) → ready_o low 31 cycles, valid_o exactly 32 cycles after accept, result 0xFFFFFFEB. Also: 0x10000 × 0x10000 → 0; a valid_i held high while busy is not accepted.
- MUL_STEP=4 build: 0x1234 × 0x10 → valid_o 8 cycles after accept, result 0x12340.
- ALUOp=1, funct=111111 → illegal_o=1, result_o=0, aluctrl_o=1111. ALUOp=0 with src 0xC and 0xA → result 0x8, illegal_o=0.
- Reset asserted at cycle 10 of a MUL → next cycle ready_o=1, valid_o=0, result_o=0, and no late valid_o pulse. A new ADD then completes normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU: ALUOp encodings, funct codes,
// ALU control codes, the multiply FSM state type and the control decoder.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_INST_REST = 2'd0;
  localparam logic [1:0] ALUOP_RTYPE     = 2'd1;
  localparam logic [1:0] ALUOP_ADDI      = 2'd2;
  localparam logic [1:0] ALUOP_MEM       = 2'd3;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_MUL = 4'b0011;
  localparam logic [3:0] CTRL_XOR = 4'b0100;
  localparam logic [3:0] CTRL_NOR = 4'b0101;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Map ALUOp/funct to a control code; anything unrecognised is ILL.
  function automatic logic [3:0] decode_ctrl(input logic [1:0] aluop,
                                             input logic [5:0] funct);
    logic [3:0] ctrl;
    ctrl = CTRL_ILL;
    case (aluop)
      ALUOP_INST_REST: ctrl = CTRL_AND;
      ALUOP_ADDI,
      ALUOP_MEM:       ctrl = CTRL_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_XOR: ctrl = CTRL_XOR;
          FUNCT_NOR: ctrl = CTRL_NOR;
          FUNCT_SLT: ctrl = CTRL_SLT;
          FUNCT_MUL: ctrl = CTRL_MUL;
          default:   ctrl = CTRL_ILL;
        endcase
      end
      default: ctrl = CTRL_ILL;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_ctrl_exec_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per
// cycle. The first partial product is folded in on the start edge and the
// last one is added combinationally on the done cycle, so done asserts
// WIDTH/MUL_STEP - 1 cycles after start with the full low-WIDTH product.
module iter_mul #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int N     = WIDTH / MUL_STEP;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] DIGIT_MASK = (WIDTH'(1) << MUL_STEP) - WIDTH'(1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_sum;

  // Shifted multiplicand times the low MUL_STEP bits of the multiplier.
  function automatic logic [WIDTH-1:0] partial(input logic [WIDTH-1:0] mc,
                                               input logic [WIDTH-1:0] mp);
    return mc * (mp & DIGIT_MASK);
  endfunction

  // Load on start, otherwise accumulate one digit and shift while busy.
  always_comb begin
    step_sum = acc_q + partial(mcand_q, mplier_q);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start && !busy_q) begin
      mcand_d  = a << MUL_STEP;
      mplier_d = b >> MUL_STEP;
      acc_d    = partial(a, b);
      cnt_d    = CNT_W'(N - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      acc_d    = step_sum;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // Multiplier state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_W'(1));
  assign product = step_sum;

endmodule

// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: decodes ALUOp/funct, computes single-cycle results into
// registered outputs and runs multiplies through iter_mul.
// Handshake: an operation transfers at a rising edge where valid_i && ready_o;
// valid_o is a one-cycle pulse with no backpressure, and ready_o drops for
// the duration of a multiply (stall_o mirrors it for the hazard unit).
module alu_ctrl_exec
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1,
  parameter int CTRL_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [WIDTH-1:0]  src1_i,
  input  logic [WIDTH-1:0]  src2_i,
  output logic [WIDTH-1:0]  result_o,
  output logic [CTRL_W-1:0] aluctrl_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic              stall_o
);
  state_e            state_q, state_d;
  logic [3:0]        ctrl;
  logic              accept, is_mul;
  logic              mul_busy, mul_done;
  logic [WIDTH-1:0]  mul_product, alu_res;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CTRL_W-1:0] aluctrl_q, aluctrl_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;

  assign ctrl    = decode_ctrl(ALUOp_i, funct_i);
  assign is_mul  = (ctrl == CTRL_MUL);
  assign ready_o = (state_q == IDLE);
  assign stall_o = !ready_o;
  assign accept  = valid_i && ready_o;

  iter_mul #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (accept && is_mul),
    .a       (src1_i),
    .b       (src2_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; ILL and MUL produce zero here.
  always_comb begin
    alu_res = '0;
    case (ctrl)
      CTRL_ADD: alu_res = src1_i + src2_i;
      CTRL_SUB: alu_res = src1_i - src2_i;
      CTRL_AND: alu_res = src1_i & src2_i;
      CTRL_OR:  alu_res = src1_i | src2_i;
      CTRL_XOR: alu_res = src1_i ^ src2_i;
      CTRL_NOR: alu_res = ~(src1_i | src2_i);
      CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default:  alu_res = '0;
    endcase
  end

  // FSM next state and output-register next values; outputs hold by default.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    aluctrl_d = aluctrl_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = BUSY;
          end else begin
            result_d  = alu_res;
            aluctrl_d = CTRL_W'(ctrl);
            illegal_d = (ctrl == CTRL_ILL);
            valid_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d   = IDLE;
          result_d  = mul_product;
          aluctrl_d = CTRL_W'(CTRL_MUL);
          illegal_d = 1'b0;
          valid_d   = 1'b1;
        end else if (!mul_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over a simultaneous accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      result_q  <= '0;
      aluctrl_q <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      aluctrl_q <= aluctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign result_o  = result_q;
  assign aluctrl_o = aluctrl_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec: a transaction-level model predicts
// each result and the cycle it must appear, and one compare process checks
// the DUT on every falling edge. A second instance covers MUL_STEP=4.
module tb_alu_ctrl_exec;
  localparam int W = 32;
  localparam int N = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (default build) ----------------
  logic         valid_i = 1'b0;
  logic [1:0]   aluop_i = 2'd0;
  logic [5:0]   funct_i = 6'd0;
  logic [W-1:0] src1_i = '0, src2_i = '0;
  logic         ready_o, valid_o, illegal_o, stall_o;
  logic [W-1:0] result_o;
  logic [3:0]   aluctrl_o;

  alu_ctrl_exec u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(aluop_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result_o), .aluctrl_o(aluctrl_o), .valid_o(valid_o),
    .illegal_o(illegal_o), .stall_o(stall_o)
  );

  // ---------------- DUT (MUL_STEP = 4 build) ----------------
  logic         v4_i = 1'b0;
  logic [1:0]   op4_i = 2'd0;
  logic [5:0]   fn4_i = 6'd0;
  logic [W-1:0] a4_i = '0, b4_i = '0;
  logic         r4_o, v4_o, ill4_o, st4_o;
  logic [W-1:0] res4_o;
  logic [3:0]   ctl4_o;

  alu_ctrl_exec #(.MUL_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(v4_i), .ready_o(r4_o),
    .ALUOp_i(op4_i), .funct_i(fn4_i), .src1_i(a4_i), .src2_i(b4_i),
    .result_o(res4_o), .aluctrl_o(ctl4_o), .valid_o(v4_o),
    .illegal_o(ill4_o), .stall_o(st4_o)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   ctrl;
    logic         ill;
    int           due;
    logic [W-1:0] lit_res;
    logic [3:0]   lit_ctrl;
  } exp_t;
  exp_t exp_q[$];

  bit           chk_en = 1'b0;
  bit           mul_on = 1'b0;
  int           mul_e = 0;
  logic [W-1:0] last_res = '0;
  logic [3:0]   last_ctrl = '0;
  logic         last_ill = 1'b0;
  bit           p4 = 1'b0;
  int           due4 = 0;
  logic [W-1:0] val4 = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  // Unit accepts in the cycle after edge c unless a multiply started at
  // edge mul_e still occupies it (cycles mul_e .. mul_e+N-2).
  function automatic bit model_ready(input int c);
    return !(mul_on && c >= mul_e && c <= mul_e + N - 2);
  endfunction

  // What the operation must produce, straight from the instruction semantics.
  function automatic void model_calc(input logic [1:0] op, input logic [5:0] fn,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic [3:0] ctrl,
                                     output logic ill, output bit is_mul);
    res = '0; ctrl = 4'b1111; ill = 1'b0; is_mul = 1'b0;
    if (op == 2'd0) begin
      ctrl = 4'b0000; res = a & b;
    end else if (op == 2'd2 || op == 2'd3) begin
      ctrl = 4'b0010; res = a + b;
    end else begin
      case (fn)
        6'h20: begin ctrl = 4'b0010; res = a + b; end
        6'h22: begin ctrl = 4'b0110; res = a - b; end
        6'h24: begin ctrl = 4'b0000; res = a & b; end
        6'h25: begin ctrl = 4'b0001; res = a | b; end
        6'h26: begin ctrl = 4'b0100; res = a ^ b; end
        6'h27: begin ctrl = 4'b0101; res = ~(a | b); end
        6'h2a: begin ctrl = 4'b0111; res = ($signed(a) < $signed(b)) ? 1 : 0; end
        6'h18: begin ctrl = 4'b0011; res = a * b; is_mul = 1'b1; end
        default: begin ctrl = 4'b1111; res = '0; ill = 1'b1; end
      endcase
    end
  endfunction

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    bit   rdy;
    bit   due_now;
    bit   d4;
    if (chk_en) begin
      rdy = model_ready(cyc);
      chk("ready_o", 32'(ready_o), 32'(rdy));
      chk("stall_o", 32'(stall_o), 32'(!rdy));
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("valid_o", 32'(valid_o), 32'(due_now));
      if (due_now) begin
        e = exp_q.pop_front();
        last_res  = e.res;
        last_ctrl = e.ctrl;
        last_ill  = e.ill;
        chk("lit_result", result_o, e.lit_res);
        chk("lit_aluctrl", 32'(aluctrl_o), 32'(e.lit_ctrl));
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        exp_q.delete(0);
      end
      chk("result_o", result_o, last_res);
      chk("aluctrl_o", 32'(aluctrl_o), 32'(last_ctrl));
      chk("illegal_o", 32'(illegal_o), 32'(last_ill));
      // MUL_STEP=4 instance
      d4 = p4 && (cyc == due4);
      chk("step4_valid", 32'(v4_o), 32'(d4));
      if (d4) begin
        chk("step4_result", res4_o, val4);
        p4 = 1'b0;
      end else if (p4 && cyc > due4) begin
        p4 = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] lres, input logic [3:0] lctrl);
    exp_t e;
    bit   m;
    while (!model_ready(cyc)) tick();
    valid_i = 1'b1; aluop_i = op; funct_i = fn; src1_i = a; src2_i = b;
    tick();
    valid_i = 1'b0;
    model_calc(op, fn, a, b, e.res, e.ctrl, e.ill, m);
    e.due      = m ? cyc + N - 1 : cyc;
    e.lit_res  = lres;
    e.lit_ctrl = lctrl;
    if (m) begin
      mul_on = 1'b1;
      mul_e  = cyc;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset_model();
    exp_q.delete();
    mul_on    = 1'b0;
    last_res  = '0;
    last_ctrl = '0;
    last_ill  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i  = 1'b0;
    chk_en = 1'b1;
    tick();

    // basic add / sub
    send(2'd1, 6'h20, 32'd5, 32'd7, 32'd12, 4'b0010);
    tick();
    send(2'd1, 6'h22, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0110);
    tick(); tick();

    // back-to-back SLT, XOR, NOR
    send(2'd1, 6'h2a, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111);
    send(2'd1, 6'h26, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0100);
    send(2'd1, 6'h27, 32'd0, 32'd0, 32'hFFFF_FFFF, 4'b0101);
    // more single-cycle corners, still back-to-back
    send(2'd1, 6'h2a, 32'd5, 32'd3, 32'd0, 4'b0111);
    send(2'd1, 6'h2a, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 4'b0111);
    send(2'd1, 6'h25, 32'h00FF_00FF, 32'h0F0F_0000, 32'h0FFF_00FF, 4'b0001);
    send(2'd1, 6'h20, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0010);
    send(2'd2, 6'h22, 32'd100, 32'hFFFF_FFFF, 32'd99, 4'b0010);
    send(2'd3, 6'h3f, 32'h1000, 32'h24, 32'h1024, 4'b0010);
    tick();

    // illegal funct and ALUOp 0
    send(2'd1, 6'h3f, 32'h1234, 32'h5678, 32'd0, 4'b1111);
    send(2'd0, 6'h20, 32'hC, 32'hA, 32'h8, 4'b0000);
    send(2'd1, 6'h00, 32'd9, 32'd9, 32'd0, 4'b1111);
    tick();

    // MUL 7 x -3 with valid_i held high while busy
    send(2'd1, 6'h18, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 4'b0011);
    valid_i = 1'b1; aluop_i = 2'd1; funct_i = 6'h20; src1_i = 32'd1; src2_i = 32'd1;
    repeat (10) tick();
    valid_i = 1'b0;
    send(2'd1, 6'h18, 32'h1_0000, 32'h1_0000, 32'd0, 4'b0011);
    send(2'd1, 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 4'b0011);
    // single-cycle op accepted right as the multiplier frees up
    send(2'd1, 6'h24, 32'hFF00, 32'h0FF0, 32'h0F00, 4'b0000);
    tick();

    // reset in the middle of a multiply
    send(2'd1, 6'h18, 32'h55, 32'h3, 32'hFF, 4'b0011);
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    do_reset_model();
    repeat (N + 4) tick();
    send(2'd1, 6'h20, 32'd2, 32'd3, 32'd5, 4'b0010);
    tick();

    // MUL_STEP = 4 instance: 0x1234 x 0x10, result 8 cycles after accept
    v4_i = 1'b1; op4_i = 2'd1; fn4_i = 6'h18; a4_i = 32'h1234; b4_i = 32'h10;
    tick();
    v4_i = 1'b0;
    p4   = 1'b1;
    due4 = cyc + 7;
    val4 = 32'h0001_2340;

    repeat (N + 8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
